// File: rtl/dcache_pkg.sv
// dcache_pkg -- shared definitions for the direct-mapped data cache.
//
// Holds the FSM state encoding, the default geometry (LINES / LINE_WORDS),
// the address-field width constants and a helper that derives the tag
// width from the geometry.
//
// Optional feature macro used by the cache: DCACHE_PERF_CNT_EN.
package dcache_pkg;

    localparam int ADDR_W         = 12;              // byte address width
    localparam int DATA_W         = 32;              // word width
    localparam int BYTE_OFF_W     = 2;               // byte-in-word bits (ignored)
    localparam int WADDR_W        = ADDR_W - BYTE_OFF_W;

    localparam int DEF_LINES      = 16;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    // Tag bits left over once the index and word offset are taken out of
    // the word address.
    function automatic int tag_width(input int lines, input int words);
        return WADDR_W - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array -- tag, valid and data storage for the direct-mapped cache.
//
// Ports:
//   clk          clock
//   i_clr_all    clear every valid bit (driven by the cache reset)
//   i_rd_idx     read-port line index
//   i_rd_off     read-port word offset
//   o_rd_valid   valid bit of the addressed line (combinational)
//   o_rd_tag     stored tag of the addressed line (combinational)
//   o_rd_data    addressed data word (combinational)
//   i_data_we    write i_wr_data into word [i_wr_idx][i_wr_off]
//   i_wr_idx     write-port line index
//   i_wr_off     write-port word offset
//   i_wr_data    write-port data
//   i_inval      clear the valid bit of line i_wr_idx
//   i_fill_done  set valid and store i_wr_tag for line i_wr_idx
//   i_wr_tag     tag stored on i_fill_done
//
// Only the valid bits are reset; tag and data contents are meaningless
// while the line is invalid.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int  LINES      = DEF_LINES,
    parameter int  LINE_WORDS = DEF_LINE_WORDS,
    localparam int IDX_W      = $clog2(LINES),
    localparam int OFF_W      = $clog2(LINE_WORDS),
    localparam int TAG_W      = tag_width(LINES, LINE_WORDS)
) (
    input  logic              clk,
    input  logic              i_clr_all,
    input  logic [IDX_W-1:0]  i_rd_idx,
    input  logic [OFF_W-1:0]  i_rd_off,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_data_we,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [OFF_W-1:0]  i_wr_off,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_inval,
    input  logic              i_fill_done,
    input  logic [TAG_W-1:0]  i_wr_tag
);

    logic [DATA_W-1:0] r_data [LINES*LINE_WORDS];
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINES-1:0]  r_valid;

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[{i_rd_idx, i_rd_off}];

    always_ff @(posedge clk) begin
        if (i_clr_all) begin
            r_valid <= '0;
        end else if (i_fill_done) begin
            r_valid[i_wr_idx] <= 1'b1;
        end else if (i_inval) begin
            r_valid[i_wr_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_data_we) begin
            r_data[{i_wr_idx, i_wr_off}] <= i_wr_data;
        end
        if (i_fill_done) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

endmodule

// File: rtl/dcache.sv
// dcache -- direct-mapped, write-through, no-write-allocate data cache.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   dcache_read_req/write_req     load / store request (store wins if both)
//   dcache_addr                   byte address, bits [1:0] ignored
//   dcache_write_data             store data
//   dcache_read_data              load data, valid on a hit, else 0
//   dcache_stall                  request not complete, hold inputs
//   mem_req, mem_we               backing-memory request / write enable
//   mem_addr, mem_wdata           backing-memory word address / store data
//   mem_ready, mem_rdata          backing-memory completion / read data
//   hit_count, miss_count         read hit / miss counters, present only
//                                 when DCACHE_PERF_CNT_EN is defined
//   o_dbg_state                   current FSM state
//
// Memory handshake: a transfer completes on every rising edge where
// mem_req and mem_ready are both high; mem_addr/mem_we/mem_wdata stay
// stable while mem_req is high and mem_ready is low.
module dcache
    import dcache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dcache_read_req,
    input  logic              dcache_write_req,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] dcache_write_data,
    output logic [DATA_W-1:0] dcache_read_data,
    output logic              dcache_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    output state_t            o_dbg_state
);

    localparam int IDX_W   = $clog2(LINES);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int TAG_W   = tag_width(LINES, LINE_WORDS);
    localparam int TAG_LSB = ADDR_W - TAG_W;

    state_t           r_state;
    logic [OFF_W-1:0] r_cnt;
    logic [TAG_W-1:0] r_tag;
    logic [IDX_W-1:0] r_idx;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [OFF_W-1:0]  w_off;
    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_hit, w_idle, w_refill, w_write;
    logic              w_rd_hit, w_rd_miss, w_wr_start, w_fill_hs, w_last;
    logic              w_unused_addr_bits;

    assign w_tag = dcache_addr[ADDR_W-1:TAG_LSB];
    assign w_idx = dcache_addr[TAG_LSB-1 -: IDX_W];
    assign w_off = dcache_addr[BYTE_OFF_W +: OFF_W];
    assign w_unused_addr_bits = ^dcache_addr[BYTE_OFF_W-1:0];

    assign w_idle   = (r_state == ST_IDLE);
    assign w_refill = (r_state == ST_REFILL);
    assign w_write  = (r_state == ST_WRITE);

    assign w_hit      = w_rd_valid && (w_rd_tag == w_tag);
    assign w_wr_start = !reset && w_idle && dcache_write_req;
    assign w_rd_hit   = !reset && w_idle && dcache_read_req && !dcache_write_req && w_hit;
    assign w_rd_miss  = !reset && w_idle && dcache_read_req && !dcache_write_req && !w_hit;
    assign w_fill_hs  = !reset && w_refill && mem_ready;
    assign w_last     = (r_cnt == OFF_W'(LINE_WORDS - 1));

    // The array write port is shared: refill words come from memory at the
    // latched line, store hits come from the pipeline at the live address.
    // The victim line is invalidated on miss entry so an aborted refill
    // never leaves a half-written line looking valid.
    dcache_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk         (clk),
        .i_clr_all   (reset),
        .i_rd_idx    (w_idx),
        .i_rd_off    (w_off),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data),
        .i_data_we   (w_fill_hs || (w_wr_start && w_hit)),
        .i_wr_idx    (w_refill ? r_idx : w_idx),
        .i_wr_off    (w_refill ? r_cnt : w_off),
        .i_wr_data   (w_refill ? mem_rdata : dcache_write_data),
        .i_inval     (w_rd_miss),
        .i_fill_done (w_fill_hs && w_last),
        .i_wr_tag    (r_tag)
    );

    assign dcache_read_data = w_rd_hit ? w_rd_data : '0;

    // A store releases the pipeline in the same cycle its handshake completes.
    assign dcache_stall = !reset && (w_wr_start || w_rd_miss || w_refill ||
                                     (w_write && !mem_ready));

    assign mem_req   = !reset && !w_idle;
    assign mem_we    = !reset && w_write;
    assign mem_addr  = w_write  ? {dcache_addr[ADDR_W-1:BYTE_OFF_W], 2'b00} :
                       w_refill ? {r_tag, r_idx, r_cnt, 2'b00} : '0;
    assign mem_wdata = w_write ? dcache_write_data : '0;

    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dcache_write_req) begin
                        r_state <= ST_WRITE;
                    end else if (dcache_read_req && !w_hit) begin
                        r_state <= ST_REFILL;
                        r_cnt   <= '0;
                        r_tag   <= w_tag;
                        r_idx   <= w_idx;
                    end
                end
                ST_REFILL: begin
                    if (mem_ready) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // A hit completes in the single cycle it is presented; a miss is counted
    // once, on the cycle it enters REFILL.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_rd_hit)  r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_rd_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache.sv
// tb_dcache -- self-checking bench for dcache.
// Backing memory word i holds 32'hC0DE_0000 | i until stored to, so the
// expected load values below are written out by hand from that pattern.
// Stimulus and memory responses change 1-2 time units after the rising
// edge; monitors sample on the falling edge.
`timescale 1ns/1ps
module tb_dcache;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        dcache_read_req, dcache_write_req;
    logic [11:0] dcache_addr;
    logic [31:0] dcache_write_data, dcache_read_data;
    logic        dcache_stall, mem_req, mem_we, mem_ready;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    state_t      dbg_state;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    dcache dut (
        .clk               (clk),
        .reset             (reset),
        .dcache_read_req   (dcache_read_req),
        .dcache_write_req  (dcache_write_req),
        .dcache_addr       (dcache_addr),
        .dcache_write_data (dcache_write_data),
        .dcache_read_data  (dcache_read_data),
        .dcache_stall      (dcache_stall),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_ready         (mem_ready),
        .mem_rdata         (mem_rdata),
`ifdef DCACHE_PERF_CNT_EN
        .hit_count         (hit_count),
        .miss_count        (miss_count),
`endif
        .o_dbg_state       (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          hs_count  = 0;
    logic [31:0] exp_rd_q[$];
    logic [44:0] exp_mem_q[$];   // {we, addr, wdata}; wdata 0 for reads
    logic [31:0] mem [1024];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Load monitor: one completion per cycle a read is presented unstalled.
    always @(negedge clk) begin
        if (!reset && dcache_read_req && !dcache_write_req && !dcache_stall) begin
            if (exp_rd_q.size() == 0) begin
                total_cnt++;
                $display("FAIL rd_unexpected: got data 0x%08h, expected no load completion", dcache_read_data);
            end else begin
                check("rd_data", dcache_read_data, exp_rd_q.pop_front());
            end
        end
    end

    // Memory monitor: logs each handshake, applies stores to the model.
    always @(negedge clk) begin
        logic [44:0] act;
        if (!reset && mem_req && mem_ready) begin
            hs_count++;
            act = {mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)};
            if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            if (exp_mem_q.size() == 0) begin
                total_cnt++;
                $display("FAIL mem_unexpected: got we/addr/wdata 0x%0h, expected no transfer", act);
            end else begin
                check("mem_xfer", act, exp_mem_q.pop_front());
            end
        end
    end

    // Memory responder with 0..2 cycles of wait per transfer.
    initial begin
        int lat;
        lat = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            mem_ready = 1'b0;
            if (mem_req) begin
                if (lat == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[11:2]];
                    lat = $urandom_range(0, 2);
                end else begin
                    lat--;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_refill(input logic [11:0] a);
        for (int i = 0; i < 4; i++)
            exp_mem_q.push_back({1'b0, (a & 12'hFF0) + 12'(4 * i), 32'h0});
    endtask

    task automatic wait_done(input string name, output logic first_stall, output logic first_mreq);
        int n;
        n = 0;
        @(negedge clk);
        first_stall = dcache_stall;
        first_mreq  = mem_req;
        while (dcache_stall && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (dcache_stall) begin
            total_cnt++;
            $display("FAIL %s_timeout: stall 1 after 200 cycles, expected 0", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input string name, input logic [11:0] a, input logic [31:0] exp_data,
                           input logic exp_miss);
        logic fs, fm;
        exp_rd_q.push_back(exp_data);
        if (exp_miss) push_refill(a);
        dcache_addr     = a;
        dcache_read_req = 1'b1;
        wait_done(name, fs, fm);
        dcache_read_req = 1'b0;
        check({name, "_first_stall"}, fs, exp_miss);
        if (!exp_miss) check({name, "_hit_mem_req"}, fm, 1'b0);
    endtask

    task automatic do_write(input string name, input logic [11:0] a, input logic [31:0] d,
                            input logic with_read);
        logic fs, fm;
        exp_mem_q.push_back({1'b1, a & 12'hFFC, d});
        dcache_addr       = a;
        dcache_write_data = d;
        dcache_write_req  = 1'b1;
        dcache_read_req   = with_read;
        wait_done(name, fs, fm);
        dcache_write_req  = 1'b0;
        dcache_read_req   = 1'b0;
        check({name, "_first_stall"}, fs, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n, base;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        reset = 1'b1;
        dcache_read_req = 1'b0;
        dcache_write_req = 1'b0;
        dcache_addr = 12'h0;
        dcache_write_data = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", dcache_stall, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_state", dbg_state, ST_IDLE);
        check("idle_rdata", dcache_read_data, 32'h0);
        check("idle_stall", dcache_stall, 1'b0);
`ifdef DCACHE_PERF_CNT_EN
        check("rst_hit_count", hit_count, 32'h0);
        check("rst_miss_count", miss_count, 32'h0);
`endif
        @(posedge clk);
        #1;

        do_read("miss_010", 12'h010, 32'hC0DE_0004, 1'b1);
        do_read("hit_014", 12'h014, 32'hC0DE_0005, 1'b0);
        @(negedge clk);
        check("noreq_rdata", dcache_read_data, 32'h0);
        check("noreq_mem_req", mem_req, 1'b0);
        @(posedge clk);
        #1;

        do_write("wr_hit_014", 12'h014, 32'hDEAD_BEEF, 1'b0);
        do_read("rd_after_wr_014", 12'h014, 32'hDEAD_BEEF, 1'b0);

        do_write("wr_miss_120", 12'h120, 32'h1234_5678, 1'b0);
        do_read("rd_miss_120", 12'h120, 32'h1234_5678, 1'b1);
        do_read("rd_hit_124", 12'h124, 32'hC0DE_0049, 1'b0);

        do_read("conflict_210", 12'h210, 32'hC0DE_0084, 1'b1);
        do_read("evicted_010", 12'h010, 32'hC0DE_0004, 1'b1);
        do_read("refilled_014", 12'h014, 32'hDEAD_BEEF, 1'b0);

        do_write("rw_both_018", 12'h018, 32'hCAFE_F00D, 1'b1);
        do_read("rd_018", 12'h018, 32'hCAFE_F00D, 1'b0);

        // Abort a refill after two of its four transfers.
        exp_mem_q.push_back({1'b0, 12'h300, 32'h0});
        exp_mem_q.push_back({1'b0, 12'h304, 32'h0});
        base = hs_count;
        dcache_addr = 12'h300;
        dcache_read_req = 1'b1;
        n = 0;
        while (hs_count < base + 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (hs_count < base + 2) begin
            total_cnt++;
            $display("FAIL abort_timeout: %0d transfers seen, expected 2", hs_count - base);
        end
        #1;
        reset = 1'b1;
        dcache_read_req = 1'b0;
        @(negedge clk);
        check("abort_in_rst_mem_req", mem_req, 1'b0);
        check("abort_in_rst_stall", dcache_stall, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_mem_req", mem_req, 1'b0);
        check("abort_state", dbg_state, ST_IDLE);
`ifdef DCACHE_PERF_CNT_EN
        check("abort_hit_count", hit_count, 32'h0);
        check("abort_miss_count", miss_count, 32'h0);
`endif
        @(posedge clk);
        #1;
        do_read("reread_300", 12'h300, 32'hC0DE_00C0, 1'b1);
        do_read("hit_304", 12'h304, 32'hC0DE_00C1, 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
`ifdef DCACHE_PERF_CNT_EN
        check("end_hit_count", hit_count, 32'd2);
        check("end_miss_count", miss_count, 32'd1);
`endif
        check("rd_queue_drained", exp_rd_q.size(), 0);
        check("mem_queue_drained", exp_mem_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
